// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single read/write port of the data RAM between two requesters:
//   M0 - CPU load/store unit (high priority)
//   M1 - DMA/fill engine (low priority, with a starvation guard)
// Grants are combinational from the current requests and registered state. A
// {valid, owner} tag pipeline RD_LAT stages deep routes each read return back to
// the master that issued it.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   enable_i              1 = arbitration active, 0 = no new grants
//   m0_*_i / m0_*_o       CPU request (req/we/addr/wdata), grant and read return
//   m1_*_i / m1_*_o       DMA request (req/we/addr/wdata), grant and read return
//   mem_addr_o, mem_din_o, mem_we_o   RAM address, write data, write enable
//   mem_dout_i            RAM read data, valid RD_LAT clocks after the address
module data_mem_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_own_q;  // 1 = read belongs to M1
  logic              tag_vld_d, tag_own_d;
  logic              arb_en;
  logic              force_m1;

  // No grants while held in reset so nothing reaches the RAM.
  assign arb_en   = enable_i & ~reset_i;
  assign force_m1 = m1_req_i & (starve_q == StarveMax);

  // M0 wins by default; a starved M1 takes the cycle and M0 is denied.
  assign m1_gnt_o = arb_en & m1_req_i & (force_m1 | ~m0_req_i);
  assign m0_gnt_o = arb_en & m0_req_i & ~force_m1;

  // With no grant the RAM still sees M0's address/data, but never a write.
  always_comb begin
    if (m1_gnt_o) begin
      mem_addr_o = m1_addr_i;
      mem_din_o  = m1_wdata_i;
      mem_we_o   = m1_we_i;
    end else begin
      mem_addr_o = m0_addr_i;
      mem_din_o  = m0_wdata_i;
      mem_we_o   = m0_gnt_o & m0_we_i;
    end
  end

  always_comb begin
    tag_vld_d = (m0_gnt_o & ~m0_we_i) | (m1_gnt_o & ~m1_we_i);
    tag_own_d = m1_gnt_o;
  end

  // Counts consecutive denied M1 request cycles; frozen while disabled.
  always_comb begin
    starve_d = starve_q;
    if (enable_i) begin
      if (!m1_req_i || m1_gnt_o) begin
        starve_d = '0;
      end else if (starve_q < StarveMax) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_q  <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      starve_q     <= starve_d;
      tag_vld_q[0] <= tag_vld_d;
      tag_own_q[0] <= tag_own_d;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  // Reads in flight when reset is asserted are dropped, including one that
  // would surface in the reset cycle itself.
  assign m0_rvalid_o = ~reset_i & tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
  assign m1_rvalid_o = ~reset_i & tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];

  // Read data is shared; only rvalid qualifies it.
  assign m0_rdata_o = mem_dout_i;
  assign m1_rdata_o = mem_dout_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 16;
  localparam int unsigned RdLat = 2;
  localparam int unsigned Limit = 4;
  localparam int          NCyc  = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_we;

  data_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .RD_LAT      (RdLat),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_gnt_o   (m0_gnt),
    .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o (m0_rdata),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_gnt_o   (m1_gnt),
    .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o (m1_rdata),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_we_o   (mem_we),
    .mem_dout_i (mem_dout)
  );

  // RAM attached to the DUT: address sampled on the edge, data out RdLat clocks later.
  logic [DW-1:0] ram     [0:32767];
  logic [DW-1:0] shadow  [0:32767];
  logic [DW-1:0] rd_pipe [0:RdLat-1];

  always @(posedge clk) begin
    rd_pipe[0] <= ram[mem_addr];
    for (int k = 1; k < RdLat; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_we) ram[mem_addr] = mem_din;
  end
  assign mem_dout = rd_pipe[RdLat-1];

  typedef struct {
    int            due;
    bit            owner;  // 1 = M1
    logic [DW-1:0] data;
  } rd_t;

  rd_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  // Monitor: every cycle, compare read returns against the scoreboard head.
  rd_t           mon_r;
  bit            mon_e0, mon_e1;
  logic [DW-1:0] mon_d;
  always @(negedge clk) begin
    mon_e0 = 1'b0;
    mon_e1 = 1'b0;
    mon_d  = '0;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_r = sb.pop_front();
      if (mon_r.owner) mon_e1 = 1'b1;
      else             mon_e0 = 1'b1;
      mon_d = mon_r.data;
    end
    check("m0_rvalid", 32'(m0_rvalid), 32'(mon_e0));
    check("m1_rvalid", 32'(m1_rvalid), 32'(mon_e1));
    if (mon_e0) check("m0_rdata", 32'(m0_rdata), 32'(mon_d));
    if (mon_e1) check("m1_rdata", 32'(m1_rdata), 32'(mon_d));
  end

  // Driver plus reference model of the arbitration rules.
  bit            g0, g1, g0p, g1p, ew, tail;
  int            starve, phase, p0, p1;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i]    = DW'($urandom);
      shadow[i] = ram[i];
    end
    reset = 1'b1; enable = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    g0p = 1'b0; g1p = 1'b0; starve = 0;

    for (int c = 0; c < NCyc; c++) begin
      @(posedge clk);
      #1;
      phase  = (c / 500) % 3;
      tail   = (c >= NCyc - 30);
      p0     = (phase == 0) ? 95 : (phase == 1) ? 50 : 30;
      p1     = (phase == 0) ? 70 : (phase == 1) ? 50 : 30;
      reset  = (c < 3) || ($urandom_range(0, 199) == 0);
      enable = (phase == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;

      // A requester holds its request until granted, then may issue the next one.
      if (!m0_req || g0p) begin
        m0_req   = !tail && ($urandom_range(0, 99) < p0);
        m0_we    = 1'($urandom_range(0, 1));
        m0_addr  = rand_addr();
        m0_wdata = DW'($urandom);
      end
      if (!m1_req || g1p) begin
        m1_req   = !tail && ($urandom_range(0, 99) < p1);
        m1_we    = 1'($urandom_range(0, 1));
        m1_addr  = rand_addr();
        m1_wdata = DW'($urandom);
      end

      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset && enable) begin
        if (m1_req && (starve == Limit || !m0_req)) g1 = 1'b1;
        else if (m0_req)                            g0 = 1'b1;
      end
      ea = g1 ? m1_addr  : m0_addr;
      ed = g1 ? m1_wdata : m0_wdata;
      ew = g1 ? m1_we    : (g0 && m0_we);

      // Reset discards every read that has not yet returned.
      if (reset) begin
        while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
      end
      if ((g0 && !m0_we) || (g1 && !m1_we)) sb.push_back('{cyc + RdLat, g1, shadow[ea]});
      if (ew) shadow[ea] = ed;

      if (reset) starve = 0;
      else if (enable) begin
        if (!m1_req || g1)       starve = 0;
        else if (starve < Limit) starve++;
      end

      #3;
      check("m0_gnt", 32'(m0_gnt), 32'(g0));
      check("m1_gnt", 32'(m1_gnt), 32'(g1));
      check("mem_we", 32'(mem_we), 32'(ew));
      check("mem_addr", 32'(mem_addr), 32'(ea));
      check("mem_din", 32'(mem_din), 32'(ed));
      g0p = g0;
      g1p = g1;
    end

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
